// File: rtl/imm_encoder.sv
// Two-stage valid/ready encoder: packs a signed immediate into RV32I I/S/B/J fields and flags unrepresentable values.
// Optional saturating error counter (err_clr/err_count ports, ERR_CNT_W) enabled by defining IMM_ENC_ERRCNT_EN.
module imm_encoder
`ifdef IMM_ENC_ERRCNT_EN
#(
   parameter int unsigned ERR_CNT_W = 16
)
`endif
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_base,
   input  logic [31:0] in_imm,
   input  logic [1:0]  in_immsrc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_err
`ifdef IMM_ENC_ERRCNT_EN
   ,
   input  logic                 err_clr,
   output logic [ERR_CNT_W-1:0] err_count
`endif
);

   typedef enum logic [1:0] {
      FMT_I = 2'b00,
      FMT_S = 2'b01,
      FMT_B = 2'b10,
      FMT_J = 2'b11
   } imm_fmt_e;

   function automatic logic [31:0] pack_imm(input logic [31:0] base,
                                            input logic [31:0] imm,
                                            input imm_fmt_e    fmt);
      logic [31:0] w;
      w = base;
      case (fmt)
         FMT_I: w[31:20] = imm[11:0];
         FMT_S: begin
            w[31:25] = imm[11:5];
            w[11:7]  = imm[4:0];
         end
         FMT_B: begin
            w[31]    = imm[12];
            w[30:25] = imm[10:5];
            w[11:8]  = imm[4:1];
            w[7]     = imm[11];
         end
         default: begin
            w[31]    = imm[20];
            w[30:21] = imm[10:1];
            w[20]    = imm[11];
            w[19:12] = imm[19:12];
         end
      endcase
      return w;
   endfunction

   // A value fits when every bit above the field's sign bit matches it.
   function automatic logic imm_bad(input logic [31:0] imm, input imm_fmt_e fmt);
      logic bad;
      case (fmt)
         FMT_I, FMT_S: bad = !((&imm[31:11]) || !(|imm[31:11]));
         FMT_B:        bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
         default:      bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      endcase
      return bad;
   endfunction

   logic        s1_valid;
   logic [31:0] s1_instr;
   logic        s1_err;
   logic        s2_load;
   imm_fmt_e    fmt;

   assign fmt      = imm_fmt_e'(in_immsrc);
   assign s2_load  = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || s2_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_instr <= '0;
         s1_err   <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_instr <= pack_imm(in_base, in_imm, fmt);
            s1_err   <= imm_bad(in_imm, fmt);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_err   <= 1'b0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         out_instr <= s1_instr;
         out_err   <= s1_err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef IMM_ENC_ERRCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (err_clr) begin
         err_count <= '0;
      end else if (out_valid && out_ready && out_err && (err_count != '1)) begin
         err_count <= err_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors, backpressure, hold stability, mid-stream reset.
// Counter checks are built when IMM_ENC_ERRCNT_EN is defined.
module tb_imm_encoder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_base;
   logic [31:0] in_imm;
   logic [1:0]  in_immsrc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;
`ifdef IMM_ENC_ERRCNT_EN
   logic        err_clr;
   logic [15:0] err_count;
`endif

   imm_encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_base   (in_base),
      .in_imm    (in_imm),
      .in_immsrc (in_immsrc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_err   (out_err)
`ifdef IMM_ENC_ERRCNT_EN
      ,
      .err_clr   (err_clr),
      .err_count (err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic        err;
      logic [31:0] imm;
      logic [1:0]  src;
   } exp_t;

   typedef struct {
      logic [31:0] base;
      logic [31:0] imm;
      logic [1:0]  src;
      logic [31:0] instr;
      logic        err;
   } vec_t;

   vec_t vecs [18] = '{
      '{32'h00000013, 32'hFFFFF800, 2'b00, 32'h80000013, 1'b0},
      '{32'h00000013, 32'h00000800, 2'b00, 32'h80000013, 1'b1},
      '{32'h00000013, 32'h000007FF, 2'b00, 32'h7FF00013, 1'b0},
      '{32'hFFFFF013, 32'h00000005, 2'b00, 32'h005FF013, 1'b0},
      '{32'h00002023, 32'h000007FF, 2'b01, 32'h7E002FA3, 1'b0},
      '{32'h00002023, 32'hFFFFF800, 2'b01, 32'h80002023, 1'b0},
      '{32'h00002023, 32'hFFFFF7FF, 2'b01, 32'h7E002FA3, 1'b1},
      '{32'hFFFFFFFF, 32'h00000000, 2'b01, 32'h01FFF07F, 1'b0},
      '{32'h00000063, 32'hFFFFFFFC, 2'b10, 32'hFE000EE3, 1'b0},
      '{32'h00000063, 32'h00000003, 2'b10, 32'h00000163, 1'b1},
      '{32'h00000063, 32'hFFFFF000, 2'b10, 32'h80000063, 1'b0},
      '{32'h00000063, 32'h00000FFE, 2'b10, 32'h7E000FE3, 1'b0},
      '{32'h00000063, 32'h00001000, 2'b10, 32'h80000063, 1'b1},
      '{32'hFFFFFFFF, 32'h00000000, 2'b10, 32'h01FFF07F, 1'b0},
      '{32'h0000006F, 32'h00100000, 2'b11, 32'h8000006F, 1'b1},
      '{32'h0000006F, 32'h000FFFFE, 2'b11, 32'h7FFFF06F, 1'b0},
      '{32'h0000006F, 32'hFFF00000, 2'b11, 32'h8000006F, 1'b0},
      '{32'h0000006F, 32'h00000001, 2'b11, 32'h0000006F, 1'b1}
   };

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int          accepted = 0;
   int          hs_count = 0;
   int          cyc = 0;
   logic        bp_mode = 1'b0;
   logic        held_pending = 1'b0;
   logic [31:0] held_instr;
   logic        held_err;
   logic        drv_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference immediate decode, as the core's decode stage would see the word.
   function automatic logic [31:0] decode(input logic [31:0] i, input logic [1:0] src);
      case (src)
         2'b00:   return {{20{i[31]}}, i[31:20]};
         2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
         2'b10:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bp_mode) out_ready = ((cyc % 3) != 0);
   end

   // Monitor: one negedge-sampled look per cycle; handshake happens at the next posedge.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (rst_n && out_valid) begin
         if (held_pending) begin
            chk("hold_instr", out_instr, held_instr);
            chk("hold_err", {31'b0, out_err}, {31'b0, held_err});
         end
         if (out_ready) begin
            held_pending = 1'b0;
            hs_count++;
            if (sb.size() == 0) begin
               chk("spurious_out", out_instr, 32'hDEADBEEF);
            end else begin
               e = sb.pop_front();
               chk("out_instr", out_instr, e.instr);
               chk("out_err", {31'b0, out_err}, {31'b0, e.err});
               if (!e.err) chk("decode_imm", decode(out_instr, e.src), e.imm);
            end
         end else begin
            held_pending = 1'b1;
            held_instr   = out_instr;
            held_err     = out_err;
         end
      end else begin
         held_pending = 1'b0;
      end
   end

   task automatic send(input vec_t v);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         in_base   = v.base;
         in_imm    = v.imm;
         in_immsrc = v.src;
         #1;
         if (in_ready) begin
            e.instr = v.instr;
            e.err   = v.err;
            e.imm   = v.imm;
            e.src   = v.src;
            sb.push_back(e);
            @(posedge clk);
            accepted++;
            ok = 1'b1;
         end
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      #3;
      chk("drain_left", sb.size(), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_base   = '0;
      in_imm    = '0;
      in_immsrc = '0;
      out_ready = 1'b1;
      drv_done  = 1'b0;
`ifdef IMM_ENC_ERRCNT_EN
      err_clr   = 1'b0;
`endif
      repeat (2) @(negedge clk);
      #3;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_err", {31'b0, out_err}, 32'd0);
`ifdef IMM_ENC_ERRCNT_EN
      chk("rst_err_count", {16'b0, err_count}, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

      // Latency: accepted at edge k, presented after edge k+1.
      send(vecs[0]);
      idle();
      #3;
      chk("lat_early", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      #3;
      chk("lat_k1", {31'b0, out_valid}, 32'd1);
      drain();

      for (int i = 1; i < 18; i++) send(vecs[i]);
      idle();
      drain();

      // Irregular out_ready to exercise hold behaviour.
      bp_mode = 1'b1;
      for (int i = 0; i < 18; i++) send(vecs[17 - i]);
      idle();
      drain();
      bp_mode = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;

      // Backpressure: only two entries fit while out_ready is low.
      @(negedge clk);
      out_ready = 1'b0;
      accepted  = 0;
      fork
         begin
            for (int i = 0; i < 4; i++) send(vecs[4 * i + 1]);
            idle();
            drv_done = 1'b1;
         end
      join_none
      repeat (6) @(negedge clk);
      #3;
      chk("bp_accepted", accepted, 32'd2);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      @(negedge clk);
      out_ready = 1'b1;
      begin
         int hs0;
         hs0 = hs_count;
         repeat (3) @(negedge clk);
         #3;
         chk("bp_throughput", hs_count - hs0, 32'd4);
      end
      for (int i = 0; i < 50 && !drv_done; i++) @(negedge clk);
      chk("bp_drv_done", {31'b0, drv_done}, 32'd1);
      drain();

`ifdef IMM_ENC_ERRCNT_EN
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      #3;
      chk("cnt_clear", {16'b0, err_count}, 32'd0);
      send(vecs[1]);
      send(vecs[9]);
      send(vecs[14]);
      idle();
      drain();
      chk("cnt_three", {16'b0, err_count}, 32'd3);
      @(negedge clk);
      out_ready = 1'b0;
      send(vecs[6]);
      idle();
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      @(negedge clk);
      err_clr   = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      #3;
      chk("cnt_clr_wins", {16'b0, err_count}, 32'd0);
      drain();
      send(vecs[12]);
      idle();
      drain();
      chk("cnt_one", {16'b0, err_count}, 32'd1);
`endif

      // Mid-stream asynchronous reset discards in-flight entries.
      @(negedge clk);
      out_ready = 1'b0;
      send(vecs[2]);
      send(vecs[9]);
      idle();
      #3;
      chk("mid_full", {31'b0, out_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
`ifdef IMM_ENC_ERRCNT_EN
      chk("mid_rst_cnt", {16'b0, err_count}, 32'd0);
`endif
      sb.delete();
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      begin
         int stale;
         stale = 0;
         repeat (6) begin
            @(negedge clk);
            #3;
            if (out_valid) stale++;
         end
         chk("mid_no_stale", stale, 32'd0);
      end
      send(vecs[15]);
      idle();
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
